// File: rtl/is_uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART TX FSM among N_REQ byte producers.
// Tracks each frame via txct and releases the TX FSM on completion or after a watchdog timeout.
`timescale 1ns/1ps

package is_pkg_uart_controller;
  localparam int unsigned DATA_W = 8;
endpackage

module is_uart_tx_arbiter
  import is_pkg_uart_controller::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned TO_CYC = 200000
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ*DATA_W-1:0]   req_data_i,
  input  logic [N_REQ-1:0]          req_mask_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic [N_REQ-1:0]          req_done_o,
  output logic [N_REQ-1:0]          grant_o,
  output logic                      busy_o,
  output logic                      timeout_o,
  output logic                      tx_rdy_t_o,
  output logic [DATA_W-1:0]         tx_data_r_o,
  input  logic                      txct_r_i
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = $clog2(TO_CYC + 1);

  typedef enum logic [1:0] {IDLE, WSTART, WDONE} state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     ptr, ptr_nxt, owner, owner_nxt, ptr_adv;
  logic [CW-1:0]     wd, wd_nxt;
  logic [N_REQ-1:0]  elig, win_oh;
  logic [IW-1:0]     win_idx, slot;
  logic              win_any;
  logic              accept, finish, expire;

  logic [N_REQ-1:0]  ready_nxt, done_nxt, grant_nxt;
  logic              busy_nxt, timeout_nxt, tx_rdy_nxt;
  logic [DATA_W-1:0] data_nxt;

  assign elig = req_valid_i & req_mask_i;

  // Search starts at ptr and wraps, so the most recently served requester is checked last.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    slot    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      slot = IW'((32'(ptr) + i) % N_REQ);
      if (!win_any && elig[slot]) begin
        win_any = 1'b1;
        win_idx = slot;
      end
    end
  end

  assign win_oh  = N_REQ'(1) << win_idx;
  assign ptr_adv = (owner == IW'(N_REQ - 1)) ? '0 : owner + IW'(1);

  assign accept = (state == IDLE) && win_any && txct_r_i;
  assign finish = (state == WDONE) && txct_r_i;
  // Completion has priority over expiry on the same cycle.
  assign expire = (state != IDLE) && (wd == CW'(TO_CYC)) && !finish;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      wd          <= '0;
      req_ready_o <= '0;
      req_done_o  <= '0;
      grant_o     <= '0;
      busy_o      <= 1'b0;
      timeout_o   <= 1'b0;
      tx_rdy_t_o  <= 1'b0;
      tx_data_r_o <= '0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      owner       <= owner_nxt;
      wd          <= wd_nxt;
      req_ready_o <= ready_nxt;
      req_done_o  <= done_nxt;
      grant_o     <= grant_nxt;
      busy_o      <= busy_nxt;
      timeout_o   <= timeout_nxt;
      tx_rdy_t_o  <= tx_rdy_nxt;
      tx_data_r_o <= data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = WSTART;
      WSTART: begin
        if (expire)         state_nxt = IDLE;
        else if (!txct_r_i) state_nxt = WDONE;
      end
      WDONE:   if (finish || expire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_nxt   = '0;
    done_nxt    = '0;
    timeout_nxt = 1'b0;
    tx_rdy_nxt  = 1'b0;
    grant_nxt   = grant_o;
    busy_nxt    = busy_o;
    data_nxt    = tx_data_r_o;
    ptr_nxt     = ptr;
    owner_nxt   = owner;
    wd_nxt      = wd;
    if (accept) begin
      data_nxt   = req_data_i[32'(win_idx) * DATA_W +: DATA_W];
      grant_nxt  = win_oh;
      ready_nxt  = win_oh;
      tx_rdy_nxt = 1'b1;
      busy_nxt   = 1'b1;
      wd_nxt     = '0;
      owner_nxt  = win_idx;
    end else if (finish) begin
      done_nxt  = grant_o;
      ptr_nxt   = ptr_adv;
      grant_nxt = '0;
      busy_nxt  = 1'b0;
    end else if (expire) begin
      timeout_nxt = 1'b1;
      ptr_nxt     = ptr_adv;
      grant_nxt   = '0;
      busy_nxt    = 1'b0;
    end else if (state != IDLE) begin
      wd_nxt = wd + CW'(1);
    end
  end

endmodule

// File: tb/tb_is_uart_tx_arbiter.sv
// Bench for is_uart_tx_arbiter: vector table, corner-case sequences and randomized
// transfers checked against a round-robin reference model.
`timescale 1ns/1ps

module tb_is_uart_tx_arbiter;

  localparam int TO_CYC = 100;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [3:0]  req_valid_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_mask_i;
  logic [3:0]  req_ready_o, req_done_o, grant_o;
  logic        busy_o, timeout_o, tx_rdy_t_o;
  logic [7:0]  tx_data_r_o;
  logic        txct_r_i;

  logic [7:0]  rd [4];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          mptr  = 0;

  assign req_data_i = {rd[3], rd[2], rd[1], rd[0]};

  always #5 clk_i = ~clk_i;

  is_uart_tx_arbiter #(.N_REQ(4), .TO_CYC(TO_CYC)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_mask_i(req_mask_i), .req_ready_o(req_ready_o), .req_done_o(req_done_o),
    .grant_o(grant_o), .busy_o(busy_o), .timeout_o(timeout_o), .tx_rdy_t_o(tx_rdy_t_o),
    .tx_data_r_o(tx_data_r_o), .txct_r_i(txct_r_i)
  );

  typedef struct {
    logic [3:0] valid;
    logic [3:0] mask;
    logic [3:0] mid_mask;
    logic [7:0] data;
    int         fall;
    int         rise;
    int         exp;
  } vec_t;

  vec_t tbl [12];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: first eligible requester at or after the pointer, wrapping around.
  function automatic int model_winner(input logic [3:0] e, input int p);
    for (int k = 0; k < 4; k++)
      if (e[(p + k) % 4]) return (p + k) % 4;
    return 0;
  endfunction

  task automatic do_reset();
    rstn_i = 1'b0;
    repeat (2) tick();
    rstn_i = 1'b1;
    mptr = 0;
  endtask

  task automatic accept(input int exp_idx, input bit reload);
    logic [3:0] oh;
    logic [7:0] exp_d;
    int waited;
    oh = 4'b1 << exp_idx;
    exp_d = rd[exp_idx];
    waited = 0;
    do begin
      tick();
      waited++;
    end while (req_ready_o == 4'b0 && waited < 20);
    check("accept_latency", 32'(waited), 32'd1);
    check("ready", 32'(req_ready_o), 32'(oh));
    check("strobe", 32'(tx_rdy_t_o), 32'd1);
    check("tx_data", 32'(tx_data_r_o), 32'(exp_d));
    check("grant", 32'({busy_o, grant_o}), 32'({1'b1, oh}));
    if (reload) rd[exp_idx] = 8'($urandom);
    else req_valid_i[exp_idx] = 1'b0;
  endtask

  task automatic transfer(input int fall_d, input int rise_d, input int exp_idx,
                          input logic [3:0] mid_mask, input bit reload);
    logic [3:0] oh;
    logic [7:0] exp_d;
    bit stable, quiet;
    oh = 4'b1 << exp_idx;
    exp_d = rd[exp_idx];
    accept(exp_idx, reload);
    req_mask_i = mid_mask;
    tick();
    check("strobe_one_cycle", 32'({req_ready_o, tx_rdy_t_o}), 32'd0);
    stable = 1'b1;
    quiet = 1'b1;
    repeat (fall_d - 1) tick();
    txct_r_i = 1'b0;
    repeat (rise_d) begin
      tick();
      if (tx_data_r_o !== exp_d || grant_o !== oh || busy_o !== 1'b1) stable = 1'b0;
      if (req_done_o !== 4'b0 || timeout_o !== 1'b0) quiet = 1'b0;
    end
    check("hold_during_frame", 32'(stable), 32'd1);
    check("no_early_done", 32'(quiet), 32'd1);
    txct_r_i = 1'b1;
    tick();
    check("done", 32'(req_done_o), 32'(oh));
    check("release", 32'({timeout_o, busy_o, grant_o}), 32'd0);
    mptr = (exp_idx + 1) % 4;
  endtask

  task automatic watchdog(input int fall_at, input int rise_at, input int exp_idx, input bit exp_done);
    logic [3:0] oh;
    bit quiet;
    oh = 4'b1 << exp_idx;
    quiet = 1'b1;
    accept(exp_idx, 1'b0);
    for (int t = 1; t <= TO_CYC; t++) begin
      tick();
      if (req_done_o !== 4'b0 || timeout_o !== 1'b0) quiet = 1'b0;
      if (t == fall_at) txct_r_i = 1'b0;
      if (t == rise_at) txct_r_i = 1'b1;
    end
    check("wd_quiet", 32'(quiet), 32'd1);
    tick();
    check("wd_timeout", 32'(timeout_o), exp_done ? 32'd0 : 32'd1);
    check("wd_done", 32'(req_done_o), exp_done ? 32'(oh) : 32'd0);
    check("wd_release", 32'({busy_o, grant_o}), 32'd0);
    txct_r_i = 1'b1;
    mptr = (exp_idx + 1) % 4;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit blocked_ok, quiet;
    int e;
    tbl[0]  = '{4'b0010, 4'b1111, 4'b1111, 8'hA5, 3, 50, 1};
    tbl[1]  = '{4'b1111, 4'b1111, 4'b1111, 8'h3C, 2,  5, 2};
    tbl[2]  = '{4'b1111, 4'b1111, 4'b1111, 8'h5A, 1,  1, 3};
    tbl[3]  = '{4'b0110, 4'b1111, 4'b1111, 8'h00, 4,  7, 1};
    tbl[4]  = '{4'b1011, 4'b1011, 4'b1011, 8'hFF, 2,  3, 3};
    tbl[5]  = '{4'b1111, 4'b1011, 4'b1011, 8'h81, 3,  4, 0};
    tbl[6]  = '{4'b1111, 4'b1011, 4'b1011, 8'h7E, 2,  6, 1};
    tbl[7]  = '{4'b1111, 4'b1011, 4'b1111, 8'hC3, 3,  8, 3};
    tbl[8]  = '{4'b0100, 4'b1111, 4'b1111, 8'h24, 2,  2, 2};
    tbl[9]  = '{4'b0001, 4'b1111, 4'b1111, 8'h99, 1,  3, 0};
    tbl[10] = '{4'b1000, 4'b1100, 4'b1100, 8'h42, 2,  2, 3};
    tbl[11] = '{4'b0011, 4'b0011, 4'b0011, 8'h18, 3,  9, 0};

    rstn_i = 1'b0;
    txct_r_i = 1'b1;
    req_valid_i = '0;
    req_mask_i = 4'hF;
    for (int k = 0; k < 4; k++) rd[k] = '0;
    repeat (3) tick();
    check("reset_outputs", {req_ready_o, req_done_o, grant_o, busy_o, timeout_o, tx_rdy_t_o, tx_data_r_o, 7'd0}, 32'd0);
    rstn_i = 1'b1;
    tick();

    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < 4; k++) rd[k] = (k == tbl[r].exp) ? tbl[r].data : 8'(~tbl[r].data ^ 8'(k));
      req_valid_i = tbl[r].valid;
      req_mask_i  = tbl[r].mask;
      transfer(tbl[r].fall, tbl[r].rise, tbl[r].exp, tbl[r].mid_mask, 1'b0);
    end
    req_valid_i = '0;

    // Fairness: everyone held valid and reloaded, back-to-back issues.
    do_reset();
    req_mask_i = 4'hF;
    for (int k = 0; k < 4; k++) rd[k] = 8'(8'h10 * k + 1);
    req_valid_i = 4'hF;
    for (int i = 0; i < 5; i++) transfer(2, 3, i % 4, 4'hF, 1'b1);
    req_valid_i = '0;

    // Issue blocked while the TX FSM reports a frame on the line.
    req_valid_i = 4'b0100;
    txct_r_i = 1'b0;
    blocked_ok = 1'b1;
    repeat (5) begin
      tick();
      if (req_ready_o !== 4'b0 || busy_o !== 1'b0 || tx_rdy_t_o !== 1'b0) blocked_ok = 1'b0;
    end
    check("blocked_issue", 32'(blocked_ok), 32'd1);
    txct_r_i = 1'b1;
    transfer(2, 4, model_winner(req_valid_i & req_mask_i, mptr), 4'hF, 1'b0);
    req_valid_i = '0;

    // Watchdog: stuck in WSTART, stuck in WDONE, completion coinciding with expiry.
    do_reset();
    req_valid_i = 4'b0001;
    watchdog(0, 0, 0, 1'b0);
    req_valid_i = 4'b0011;
    transfer(2, 3, model_winner(req_valid_i & req_mask_i, mptr), 4'hF, 1'b0);
    req_valid_i = 4'b0100;
    watchdog(3, 0, 2, 1'b0);
    req_valid_i = 4'b1000;
    watchdog(3, TO_CYC, 3, 1'b1);
    req_valid_i = '0;

    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < 4; k++) rd[k] = 8'($urandom);
      req_valid_i = 4'($urandom_range(1, 15));
      req_mask_i  = 4'($urandom);
      if ((req_valid_i & req_mask_i) == 4'b0) req_mask_i = req_mask_i | req_valid_i;
      e = model_winner(req_valid_i & req_mask_i, mptr);
      transfer($urandom_range(1, 4), $urandom_range(1, 20), e, 4'($urandom), 1'($urandom));
    end
    req_valid_i = '0;
    req_mask_i = 4'hF;

    // Asynchronous reset while waiting for frame end.
    req_valid_i = 4'b0100;
    rd[2] = 8'h6D;
    accept(2, 1'b0);
    tick();
    txct_r_i = 1'b0;
    repeat (3) tick();
    #3 rstn_i = 1'b0;
    #1;
    check("async_reset", {req_ready_o, req_done_o, grant_o, busy_o, timeout_o, tx_rdy_t_o, tx_data_r_o, 7'd0}, 32'd0);
    txct_r_i = 1'b1;
    tick();
    rstn_i = 1'b1;
    mptr = 0;
    quiet = 1'b1;
    repeat (3) begin
      tick();
      if (req_done_o !== 4'b0 || timeout_o !== 1'b0 || busy_o !== 1'b0) quiet = 1'b0;
    end
    check("no_done_after_reset", 32'(quiet), 32'd1);
    req_valid_i = 4'hF;
    transfer(2, 3, model_winner(req_valid_i & req_mask_i, mptr), 4'hF, 1'b0);
    req_valid_i = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
